// File: rtl/display_share_arbiter_pkg.sv
// Shared display bundle widths and arbiter types.
// Used by the arbiter, the 7-segment driver and display clients.
package display_share_arbiter_pkg;

  localparam int DISPLAY_DIGITS = 6;
  localparam int DISPLAY_DATA_W = 4 * DISPLAY_DIGITS;
  localparam int DISPLAY_DP_W   = DISPLAY_DIGITS;

  localparam int MAX_CLIENTS = 8;
  localparam int IDX_W       = 3;

  typedef enum logic {
    ST_IDLE,
    ST_SHOW
  } dsa_state_e;

  typedef struct packed {
    logic [DISPLAY_DATA_W-1:0] data;
    logic [DISPLAY_DIGITS-1:0] de;
    logic [DISPLAY_DP_W-1:0]   dp;
  } disp_bundle_t;

endpackage

// File: rtl/display_share_arbiter_rr_sel.sv
// Round-robin pick: first req after ptr, cyclic, minus excl.
// Ports: req, ptr, excl in; found, idx out.
module rr_priority_select
  import display_share_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N-1:0]     excl,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0] cand;

  assign cand = req & ~excl;

  always_comb begin
    int pos;
    pos   = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!found && cand[pos]) begin
        found = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/display_share_arbiter.sv
// Round-robin, dwell-limited sharing of one 6-digit display.
// Ports: clk, reset_n, req/bundles in; gnt, owner, busy, bundle out.
module display_share_arbiter
  import display_share_arbiter_pkg::*;
#(
  parameter  int NUM_CLIENTS  = 4,
  parameter  int DWELL_CYCLES = 8,
  localparam int CNT_W = $clog2(DWELL_CYCLES + 1)
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_CLIENTS-1:0]                 req,
  input  logic [DISPLAY_DATA_W*NUM_CLIENTS-1:0]  req_data,
  input  logic [DISPLAY_DIGITS*NUM_CLIENTS-1:0]  req_digit_enable,
  input  logic [DISPLAY_DP_W*NUM_CLIENTS-1:0]    req_dp_enable,
  output logic [NUM_CLIENTS-1:0]                 gnt,
  output logic [IDX_W-1:0]                       owner,
  output logic                                   busy,
  output logic [DISPLAY_DATA_W-1:0]              data,
  output logic [DISPLAY_DIGITS-1:0]              digit_enable,
  output logic [DISPLAY_DP_W-1:0]                decimal_point_enable
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);

  dsa_state_e          state_q, state_d;
  logic [NUM_CLIENTS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic                busy_q, busy_d;
  disp_bundle_t        out_q, out_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Padded to 8 so a 3-bit index never leaves the array.
  logic [MAX_CLIENTS-1:0] req_pad;
  disp_bundle_t           cl [MAX_CLIENTS];

  logic [NUM_CLIENTS-1:0] excl;
  logic                   found;
  logic [IDX_W-1:0]       win;

  assign req_pad = MAX_CLIENTS'(req);

  for (genvar i = 0; i < MAX_CLIENTS; i++) begin : g_cl
    if (i < NUM_CLIENTS) begin : g_on
      assign cl[i].data =
        req_data[DISPLAY_DATA_W*i +: DISPLAY_DATA_W];
      assign cl[i].de =
        req_digit_enable[DISPLAY_DIGITS*i +: DISPLAY_DIGITS];
      assign cl[i].dp =
        req_dp_enable[DISPLAY_DP_W*i +: DISPLAY_DP_W];
    end else begin : g_off
      assign cl[i] = '0;
    end
  end

  // In SHOW the pointer equals the owner; masking it
  // makes the same picker serve the preemptive switch.
  assign excl = (state_q == ST_SHOW) ? gnt_q : '0;

  rr_priority_select #(
    .N (NUM_CLIENTS)
  ) u_sel (
    .req   (req),
    .ptr   (rr_q),
    .excl  (excl),
    .found (found),
    .idx   (win)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    out_d   = out_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        out_d.de = '0;
        out_d.dp = '0;
        if (found) begin
          state_d = ST_SHOW;
          gnt_d   = NUM_CLIENTS'(1) << win;
          owner_d = win;
          busy_d  = 1'b1;
          out_d   = cl[win];
          cnt_d   = CNT_LOAD;
          rr_d    = win;
        end
      end
      ST_SHOW: begin
        if (!req_pad[owner_q]) begin
          state_d  = ST_IDLE;
          gnt_d    = '0;
          busy_d   = 1'b0;
          out_d.de = '0;
          out_d.dp = '0;
        end else if (cnt_q == '0 && found) begin
          gnt_d   = NUM_CLIENTS'(1) << win;
          owner_d = win;
          out_d   = cl[win];
          cnt_d   = CNT_LOAD;
          rr_d    = win;
        end else begin
          out_d = cl[owner_q];
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      out_q   <= '0;
      rr_q    <= IDX_W'(NUM_CLIENTS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      out_q   <= out_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt                  = gnt_q;
  assign owner                = owner_q;
  assign busy                 = busy_q;
  assign data                 = out_q.data;
  assign digit_enable         = out_q.de;
  assign decimal_point_enable = out_q.dp;

endmodule

// File: tb/tb_display_share_arbiter.sv
// Directed bench for display_share_arbiter (4 clients, dwell 8).
// Inputs driven and outputs sampled on the falling edge.
module tb_display_share_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [95:0] req_data;
  logic [23:0] req_de;
  logic [23:0] req_dp;
  logic [3:0]  gnt;
  logic [2:0]  owner;
  logic        busy;
  logic [23:0] data;
  logic [5:0]  digit_enable;
  logic [5:0]  dp_enable;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  display_share_arbiter #(
    .NUM_CLIENTS  (4),
    .DWELL_CYCLES (8)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .req                  (req),
    .req_data             (req_data),
    .req_digit_enable     (req_de),
    .req_dp_enable        (req_dp),
    .gnt                  (gnt),
    .owner                (owner),
    .busy                 (busy),
    .data                 (data),
    .digit_enable         (digit_enable),
    .decimal_point_enable (dp_enable)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_client(input int i,
                            input logic [23:0] d,
                            input logic [5:0] e,
                            input logic [5:0] p);
    req_data[24*i +: 24] = d;
    req_de[6*i +: 6]     = e;
    req_dp[6*i +: 6]     = p;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = 4'b0000;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] eg;
    reset_n  = 1'b0;
    req      = '0;
    req_data = '0;
    req_de   = '0;
    req_dp   = '0;
    @(negedge clk);
    do_reset();

    // reset values
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_de", 32'(digit_enable), 32'h0);
    chk("rst_dp", 32'(dp_enable), 32'h0);

    // 1: single grant, one-cycle latency
    set_client(2, 24'hABCDEF, 6'h3F, 6'h01);
    req = 4'b0100;
    chk("t1_pre_busy", 32'(busy), 32'h0);
    tick();
    chk("t1_gnt", 32'(gnt), 32'h4);
    chk("t1_owner", 32'(owner), 32'h2);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_data", 32'(data), 32'hABCDEF);
    chk("t1_de", 32'(digit_enable), 32'h3F);
    chk("t1_dp", 32'(dp_enable), 32'h01);
    req = 4'b0000;
    tick();
    chk("t1_rel_gnt", 32'(gnt), 32'h0);
    chk("t1_rel_busy", 32'(busy), 32'h0);
    chk("t1_rel_de", 32'(digit_enable), 32'h0);
    chk("t1_rel_dp", 32'(dp_enable), 32'h0);
    chk("t1_rel_data", 32'(data), 32'hABCDEF);

    // 2: dwell-limited preemption, no blank
    do_reset();
    set_client(0, 24'h111111, 6'h3F, 6'h00);
    set_client(3, 24'h333333, 6'h0F, 6'h08);
    req = 4'b0001;
    tick();
    chk("t2_g0", 32'(gnt), 32'h1);
    tick();
    req = 4'b1001;
    for (int c = 2; c <= 7; c++) begin
      tick();
      chk($sformatf("t2_hold%0d", c), 32'(gnt), 32'h1);
      chk($sformatf("t2_busy%0d", c), 32'(busy), 32'h1);
    end
    tick();
    chk("t2_sw_gnt", 32'(gnt), 32'h8);
    chk("t2_sw_owner", 32'(owner), 32'h3);
    chk("t2_sw_busy", 32'(busy), 32'h1);
    chk("t2_sw_data", 32'(data), 32'h333333);
    chk("t2_sw_de", 32'(digit_enable), 32'h0F);
    chk("t2_sw_dp", 32'(dp_enable), 32'h08);

    // 3: all requesting, 0,1,2,3,0 each for 8 cycles
    do_reset();
    set_client(0, 24'h000AAA, 6'h01, 6'h00);
    set_client(1, 24'h111BBB, 6'h02, 6'h00);
    set_client(2, 24'h222CCC, 6'h04, 6'h00);
    set_client(3, 24'h333DDD, 6'h08, 6'h00);
    req = 4'b1111;
    tick();
    for (int k = 0; k < 40; k++) begin
      eg = 4'b0001 << ((k / 8) % 4);
      chk($sformatf("t3_gnt%0d", k), 32'(gnt), 32'(eg));
      chk($sformatf("t3_own%0d", k), 32'(owner),
          32'((k / 8) % 4));
      tick();
    end

    // 4: owner drop mid-dwell gives one blank cycle
    do_reset();
    set_client(1, 24'h121212, 6'h3F, 6'h02);
    set_client(2, 24'h232323, 6'h3C, 6'h04);
    req = 4'b0010;
    tick();
    chk("t4_g1", 32'(gnt), 32'h2);
    req = 4'b0110;
    tick();
    chk("t4_hold1", 32'(owner), 32'h1);
    tick();
    chk("t4_hold2", 32'(owner), 32'h1);
    req = 4'b0100;
    tick();
    chk("t4_blank_busy", 32'(busy), 32'h0);
    chk("t4_blank_de", 32'(digit_enable), 32'h0);
    chk("t4_blank_gnt", 32'(gnt), 32'h0);
    tick();
    chk("t4_g2", 32'(gnt), 32'h4);
    chk("t4_g2_owner", 32'(owner), 32'h2);
    chk("t4_g2_data", 32'(data), 32'h232323);
    chk("t4_g2_de", 32'(digit_enable), 32'h3C);

    // 5: sole requester keeps display, data follows live
    do_reset();
    set_client(1, 24'h123456, 6'h3F, 6'h00);
    req = 4'b0010;
    tick();
    chk("t5_data0", 32'(data), 32'h123456);
    for (int c = 0; c < 12; c++) begin
      tick();
      chk($sformatf("t5_gnt%0d", c), 32'(gnt), 32'h2);
    end
    set_client(1, 24'h654321, 6'h3F, 6'h00);
    #1;
    chk("t5_data_old", 32'(data), 32'h123456);
    tick();
    chk("t5_data_new", 32'(data), 32'h654321);
    chk("t5_busy", 32'(busy), 32'h1);

    // 6: async reset mid-show, then lowest index wins
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_gnt", 32'(gnt), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_de", 32'(digit_enable), 32'h0);
    chk("t6_dp", 32'(dp_enable), 32'h0);
    set_client(0, 24'h0F0F0F, 6'h11, 6'h20);
    req = 4'b1001;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6_first_gnt", 32'(gnt), 32'h1);
    chk("t6_first_owner", 32'(owner), 32'h0);
    chk("t6_first_data", 32'(data), 32'h0F0F0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/display_share_arbiter.md
Name: display_share_arbiter

Overview:
- Shares one six-digit `_7segment_display_driver` among NUM_CLIENTS requesters.
- Each client presents a request plus a display bundle: 24-bit hex data, 6-bit digit enable and 6-bit decimal-point enable.
- The arbiter grants clients round-robin, enforces a minimum dwell time per owner, and registers the owner's bundle onto the driver inputs.
- It sits directly in front of the driver; its outputs connect 1:1 to the driver's data, digit_enable and decimal_point_enable.

Parameters:
- NUM_CLIENTS, 4, number of requesters (2..8).
- DWELL_CYCLES, 8, minimum clk cycles an owner holds the display before a competing request can preempt it (>=1).
- CNT_W, $clog2(DWELL_CYCLES+1), dwell counter width (derived, not overridden).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NUM_CLIENTS  per-client display request, level-sensitive.
- req_data  input  24*NUM_CLIENTS  client i's hex nibbles at [24*i +: 24].
- req_digit_enable  input  6*NUM_CLIENTS  client i's digit enables at [6*i +: 6].
- req_dp_enable  input  6*NUM_CLIENTS  client i's decimal points at [6*i +: 6].
- gnt  output  NUM_CLIENTS  one-hot owner indication, registered.
- owner  output  3  binary index of the current owner; valid only when busy=1.
- busy  output  1  display owned by some client.
- data  output  24  to driver data.
- digit_enable  output  6  to driver digit_enable.
- decimal_point_enable  output  6  to driver decimal_point_enable.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state=IDLE; gnt=0, owner=0, busy=0, data=0, digit_enable=0, decimal_point_enable=0; rr pointer=NUM_CLIENTS-1, so client 0 has first priority; dwell counter=0.
- IDLE state:
  - Outputs blank: digit_enable=0, decimal_point_enable=0, data holds its last value.
  - If req is nonzero at edge t, the winner is the first requesting index after the rr pointer, searching cyclically upward.
  - At edge t: gnt, owner and busy=1 are registered; the winner's bundle is registered onto the outputs; the dwell counter loads DWELL_CYCLES-1; the rr pointer becomes the winner; state goes to SHOW.
  - Latency is one cycle from req to gnt and to the visible bundle.
- SHOW state, evaluated every cycle in this priority order:
  1. req[owner]=0: release. Next edge gives gnt=0, busy=0, digit_enable=0, decimal_point_enable=0, state=IDLE. There is exactly one blank cycle before any re-grant, even if other requests are pending.
  2. Dwell counter==0 and some other client requests: switch directly, with no blank cycle, to the next round-robin winner. The current owner is excluded. gnt, owner and outputs update at the next edge; the counter reloads DWELL_CYCLES-1; the rr pointer advances.
  3. Otherwise stay: outputs re-sample the owner's bundle every cycle (live follow, 1-cycle latency). The counter decrements and saturates at 0.
- Sole requester: holds the display indefinitely; the counter sits at 0.
- Simultaneous events:
  - Owner drop and dwell expiry in the same cycle: the drop wins, giving IDLE and a blank cycle.
  - A new request arriving in the same cycle as the owner's drop is served from IDLE on the following cycle.
- Invariants: gnt is always one-hot or zero. gnt[owner]=busy.
- Reset mid-SHOW: all outputs return to reset values asynchronously, and the display blanks immediately.
- Out-of-range indices (>=NUM_CLIENTS) are never selected.

Decomposition:
- Shared package/header: DISPLAY_DIGITS=6, DISPLAY_DATA_W=24, DISPLAY_DP_W=6, shared with the driver and other display clients.
- Sub-module rr_priority_select (combinational): inputs request vector, pointer, exclude mask; outputs found flag and winner index. Used for both the IDLE pick and the SHOW switch.
- FSM, counter and output registers live in the top module.

Test Plan (NUM_CLIENTS=4, DWELL_CYCLES=8):
1. Reset, then req=4'b0100 with client 2 data=24'hABCDEF, de=6'h3F, dp=6'h01 → next cycle: gnt=4'b0100, owner=2, busy=1, data=24'hABCDEF, digit_enable=6'h3F, decimal_point_enable=6'h01.
2. Client 0 owns the display; raise req[3] two cycles after the grant → owner stays 0 until 8 cycles after the grant, then gnt switches to 4'b1000 with client 3's bundle and no blank cycle.
3. All four requesting continuously → grant order 0,1,2,3,0, each owner held exactly 8 cycles.
4. Owner 1 drops req at cycle 3 of its dwell while req[2]=1 → one cycle with busy=0 and digit_enable=0, then gnt=4'b0100.
5. Sole requester client 1 changes req_data from 24'h123456 to 24'h654321 mid-SHOW → data follows one cycle later; no release while req[1] stays high.
6. Assert reset_n=0 asynchronously between edges during SHOW → gnt, busy, digit_enable and decimal_point_enable go to 0 immediately. After release, the first grant goes to the lowest requesting index.
